pcpu_seq_ctrl: RTL and testbench
================================

Name: pcpu_seq_ctrl

Overview:
- Multi-cycle control sequencer for the 16-bit PCPU datapath.
- Owns the 8-bit PC that addresses the instruction memory and latches the fetched word into the IR.
- Steps each instruction through IF/ID/EX/MEM/WB and issues the per-stage strobes to the register file, ALU flag register and data memory.
- Data memory is accessed through a req/ack handshake, so memory latency can vary.

Parameters:
- RESET_PC, 8'h00, PC value loaded at reset and on each start.
- DM_TIMEOUT, 16, maximum cycles in MEM waiting for dm_ack before the fault halt.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  global run enable; low freezes the sequencer.
- start  in  1  one-cycle pulse; launches execution from IDLE.
- instr  in  16  instruction word from instruction memory at address pc.
- zf  in  1  zero flag from the ALU flag register.
- nf  in  1  negative flag from the ALU flag register.
- cf  in  1  carry flag from the ALU flag register.
- dm_ack  in  1  data memory completion.
- pc  out  8  instruction memory address.
- ir  out  16  latched instruction.
- state  out  3  IDLE=0, IF=1, ID=2, EX=3, MEM=4, WB=5, HALTED=6.
- alu_en  out  1  ALU operate strobe.
- flag_we  out  1  flag register write.
- reg_we  out  1  register file write.
- dm_req  out  1  data memory request.
- dm_we  out  1  data memory write qualifier, valid with dm_req.
- branch_taken  out  1  one-cycle pulse when a branch is taken.
- halted  out  1  HALTED state reached.
- fault  out  2  00 none, 01 illegal opcode, 10 dm timeout.

Behaviour:
- Reset (async, reset=0):
  - pc=RESET_PC, ir=16'h0000, state=IDLE.
  - All strobes 0, halted=0, fault=00, timeout counter=0.
- Opcode is ir[15:11] and is decoded with the shared opcode defines.
- enable=0: state, pc, ir and timeout counter hold; all strobes forced to 0. Operation resumes in the same state when enable returns to 1.
- Strobes are combinational from state and ir.
- IDLE: start&enable -> pc<=RESET_PC, fault<=00, go to IF.
- IF: ir<=instr, pc<=pc+1 (8-bit wrap, FF->00), go to ID.
- ID, decode only:
  - HALT -> HALTED.
  - Undefined opcode -> HALTED, fault=01.
  - Otherwise -> EX.
- EX: alu_en=1.
  - flag_we=1 for arithmetic, logic, shift and CMP.
  - Branch condition uses flag values present in this cycle. JUMP is always taken; BZ/BNZ test zf, BN/BNN test nf, BC/BNC test cf.
  - Taken branch: pc<=ir[7:0], branch_taken=1 for this cycle only. A taken branch overrides the IF increment.
  - Next state: LOAD/STORE -> MEM; register-writing ops -> WB; CMP/branch/NOP -> IF.
- MEM: dm_req=1 held until dm_ack; dm_we=1 for STORE.
  - dm_ack=1 (including first cycle): LOAD -> WB, STORE -> IF.
  - DM_TIMEOUT cycles without dm_ack -> HALTED, fault=10, dm_req drops.
  - The timeout counter clears on MEM entry.
- WB: reg_we=1 for one cycle, go to IF.
- HALTED: halted=1; stays there until start, which behaves as from IDLE and clears halted and fault.
- Latency per instruction:
  - ALU: 4 cycles.
  - CMP/branch: 3 cycles.
  - STORE: 4+wait cycles.
  - LOAD: 5+wait cycles.
- start outside IDLE/HALTED is ignored.
- Reset mid-instruction aborts immediately; no strobe is left asserted.

Optional Feature:
- Macro: PCPU_SEQ_SINGLE_STEP_EN.
- When defined:
  - Adds input step (1-bit pulse) and state STEP=7.
  - Each instruction's final state (WB, last EX or MEM) goes to STEP instead of IF.
  - STEP exits to IF on step=1; all strobes are 0 while in STEP.
  - HALT and faults are unaffected.
- When undefined: no step port, encoding 7 is unused and unreachable.

Test Plan:
- Reset, start; IM word 0 = LOAD gr1,[gr0+0]; dm_ack after 2 wait cycles.
  -> states 1,2,3,4,4,4,5,1; dm_req high 3 cycles, dm_we=0; reg_we one cycle; pc=01 at second IF.
- ADD gr3,gr1,gr2 at pc=02.
  -> alu_en and flag_we in EX, reg_we in WB; 4 cycles total; pc=03.
- BZ target 8'h0B with zf=1 at pc=06.
  -> branch_taken pulse in EX, next IF fetches address 0B.
  -> Same instruction with zf=0: next fetch at 07, no pulse.
- HALT fetched at 0x10.
  -> halted=1 after ID, pc=11, no further strobes.
  -> start then restarts at RESET_PC with halted=0.
- STORE with dm_ack never asserted.
  -> HALTED after 16 MEM cycles, fault=10.
  -> Repeat with enable=0 for 5 cycles mid-MEM: timeout takes 5 cycles longer, dm_req=0 while disabled.
- PC at FF executing ADD.
  -> next fetch at 00.
- Async reset asserted during MEM.
  -> immediately state=0, dm_req=0, pc=RESET_PC.

Source files
------------

// File: rtl/pcpu_seq_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB control sequencer for the 16-bit PCPU datapath.
// Optional single-step mode is enabled by defining PCPU_SEQ_SINGLE_STEP_EN.
module pcpu_seq_ctrl #(
    parameter logic [7:0] RESET_PC   = 8'h00,
    parameter int         DM_TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        start,
`ifdef PCPU_SEQ_SINGLE_STEP_EN
    input  logic        step,
`endif
    input  logic [15:0] instr,
    input  logic        zf,
    input  logic        nf,
    input  logic        cf,
    input  logic        dm_ack,
    output logic [7:0]  pc,
    output logic [15:0] ir,
    output logic [2:0]  state,
    output logic        alu_en,
    output logic        flag_we,
    output logic        reg_we,
    output logic        dm_req,
    output logic        dm_we,
    output logic        branch_taken,
    output logic        halted,
    output logic [1:0]  fault
);

    localparam logic [4:0] OP_NOP   = 5'b00000;
    localparam logic [4:0] OP_HALT  = 5'b00001;
    localparam logic [4:0] OP_LOAD  = 5'b00010;
    localparam logic [4:0] OP_STORE = 5'b00011;
    localparam logic [4:0] OP_SLL   = 5'b00100;
    localparam logic [4:0] OP_SLA   = 5'b00101;
    localparam logic [4:0] OP_SRL   = 5'b00110;
    localparam logic [4:0] OP_SRA   = 5'b00111;
    localparam logic [4:0] OP_ADD   = 5'b01000;
    localparam logic [4:0] OP_ADDI  = 5'b01001;
    localparam logic [4:0] OP_SUB   = 5'b01010;
    localparam logic [4:0] OP_SUBI  = 5'b01011;
    localparam logic [4:0] OP_CMP   = 5'b01100;
    localparam logic [4:0] OP_AND   = 5'b01101;
    localparam logic [4:0] OP_OR    = 5'b01110;
    localparam logic [4:0] OP_XOR   = 5'b01111;
    localparam logic [4:0] OP_LDIH  = 5'b10000;
    localparam logic [4:0] OP_ADDC  = 5'b10001;
    localparam logic [4:0] OP_SUBC  = 5'b10010;
    localparam logic [4:0] OP_JUMP  = 5'b11000;
    localparam logic [4:0] OP_BZ    = 5'b11010;
    localparam logic [4:0] OP_BNZ   = 5'b11011;
    localparam logic [4:0] OP_BN    = 5'b11100;
    localparam logic [4:0] OP_BNN   = 5'b11101;
    localparam logic [4:0] OP_BC    = 5'b11110;
    localparam logic [4:0] OP_BNC   = 5'b11111;

    localparam int CNT_W = (DM_TIMEOUT > 1) ? $clog2(DM_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_IF     = 3'd1,
        S_ID     = 3'd2,
        S_EX     = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALTED = 3'd6
`ifdef PCPU_SEQ_SINGLE_STEP_EN
        , S_STEP = 3'd7
`endif
    } state_t;

    // Where an instruction goes once its last active stage completes.
`ifdef PCPU_SEQ_SINGLE_STEP_EN
    localparam state_t DONE_STATE = S_STEP;
`else
    localparam state_t DONE_STATE = S_IF;
`endif

    state_t           state_q;
    logic [7:0]       pc_q;
    logic [15:0]      ir_q;
    logic [1:0]       fault_q;
    logic [CNT_W-1:0] tmoCnt_q;

    logic [4:0] opcode;
    logic       isLegal, isHalt, isLoad, isStore, isRegWr, isFlagWr, isBranch, condMet;
    logic       takeBranch;

    assign opcode = ir_q[15:11];

    always_comb begin
        isLegal  = 1'b1;
        isHalt   = 1'b0;
        isLoad   = 1'b0;
        isStore  = 1'b0;
        isRegWr  = 1'b0;
        isFlagWr = 1'b0;
        isBranch = 1'b0;
        condMet  = 1'b0;
        case (opcode)
            OP_NOP:   ;
            OP_HALT:  isHalt = 1'b1;
            OP_LOAD:  isLoad = 1'b1;
            OP_STORE: isStore = 1'b1;
            OP_LDIH:  isRegWr = 1'b1;
            OP_SLL, OP_SLA, OP_SRL, OP_SRA,
            OP_ADD, OP_ADDI, OP_ADDC, OP_SUB, OP_SUBI, OP_SUBC,
            OP_AND, OP_OR, OP_XOR: begin
                isRegWr  = 1'b1;
                isFlagWr = 1'b1;
            end
            OP_CMP:   isFlagWr = 1'b1;
            OP_JUMP:  begin isBranch = 1'b1; condMet = 1'b1; end
            OP_BZ:    begin isBranch = 1'b1; condMet = zf;   end
            OP_BNZ:   begin isBranch = 1'b1; condMet = !zf;  end
            OP_BN:    begin isBranch = 1'b1; condMet = nf;   end
            OP_BNN:   begin isBranch = 1'b1; condMet = !nf;  end
            OP_BC:    begin isBranch = 1'b1; condMet = cf;   end
            OP_BNC:   begin isBranch = 1'b1; condMet = !cf;  end
            default:  isLegal = 1'b0;
        endcase
    end

    assign takeBranch = isBranch && condMet;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            ir_q     <= 16'h0000;
            fault_q  <= 2'b00;
            tmoCnt_q <= '0;
        end else if (enable) begin
            case (state_q)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        pc_q    <= RESET_PC;
                        fault_q <= 2'b00;
                        state_q <= S_IF;
                    end
                end
                S_IF: begin
                    ir_q    <= instr;
                    pc_q    <= pc_q + 8'd1;
                    state_q <= S_ID;
                end
                S_ID: begin
                    if (!isLegal) begin
                        fault_q <= 2'b01;
                        state_q <= S_HALTED;
                    end else if (isHalt) begin
                        state_q <= S_HALTED;
                    end else begin
                        state_q <= S_EX;
                    end
                end
                S_EX: begin
                    if (takeBranch) pc_q <= ir_q[7:0];
                    if (isLoad || isStore) begin
                        tmoCnt_q <= '0;
                        state_q  <= S_MEM;
                    end else if (isRegWr) begin
                        state_q <= S_WB;
                    end else begin
                        state_q <= DONE_STATE;
                    end
                end
                // An ack on the final allowed cycle still completes the access.
                S_MEM: begin
                    if (dm_ack) begin
                        state_q <= isLoad ? S_WB : DONE_STATE;
                    end else if (tmoCnt_q == CNT_W'(DM_TIMEOUT - 1)) begin
                        fault_q <= 2'b10;
                        state_q <= S_HALTED;
                    end else begin
                        tmoCnt_q <= tmoCnt_q + 1'b1;
                    end
                end
                S_WB: state_q <= DONE_STATE;
`ifdef PCPU_SEQ_SINGLE_STEP_EN
                S_STEP: if (step) state_q <= S_IF;
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Strobes are qualified by enable so a frozen sequencer drives nothing.
    assign alu_en       = enable && (state_q == S_EX);
    assign flag_we      = enable && (state_q == S_EX) && isFlagWr;
    assign branch_taken = enable && (state_q == S_EX) && takeBranch;
    assign reg_we       = enable && (state_q == S_WB);
    assign dm_req       = enable && (state_q == S_MEM);
    assign dm_we        = dm_req && isStore;
    assign halted       = (state_q == S_HALTED);

    assign pc    = pc_q;
    assign ir    = ir_q;
    assign state = state_q;
    assign fault = fault_q;

endmodule

// File: tb/tb_pcpu_seq_ctrl.sv
// Directed self-checking bench for pcpu_seq_ctrl: load/ALU/branch/halt,
// illegal opcode, data-memory timeout with an enable pause, PC wrap and async reset.
module tb_pcpu_seq_ctrl;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        start;
    logic        step;
    logic [15:0] instr;
    logic        zf, nf, cf;
    logic        dm_ack;
    logic [7:0]  pc;
    logic [15:0] ir;
    logic [2:0]  state;
    logic        alu_en, flag_we, reg_we, dm_req, dm_we, branch_taken, halted;
    logic [1:0]  fault;

    logic [15:0] imem [256];
    int testsRun;
    int testsFailed;

    assign instr = imem[pc];

    pcpu_seq_ctrl dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .start(start),
`ifdef PCPU_SEQ_SINGLE_STEP_EN
        .step(step),
`endif
        .instr(instr),
        .zf(zf),
        .nf(nf),
        .cf(cf),
        .dm_ack(dm_ack),
        .pc(pc),
        .ir(ir),
        .state(state),
        .alu_en(alu_en),
        .flag_we(flag_we),
        .reg_we(reg_we),
        .dm_req(dm_req),
        .dm_we(dm_we),
        .branch_taken(branch_taken),
        .halted(halted),
        .fault(fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drives the inputs for the coming edge, then samples 1ns after it.
    task automatic applyStimulus(input logic startIn, input logic enableIn, input logic ackIn);
        start  = startIn;
        enable = enableIn;
        dm_ack = ackIn;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
        imem[8'h00] = 16'h1100;
        imem[8'h01] = 16'h0000;
        imem[8'h02] = 16'h4312;
        imem[8'h03] = 16'hC006;
        imem[8'h06] = 16'hD00B;
        imem[8'h0B] = 16'hC006;
        imem[8'h07] = 16'hC010;
        imem[8'h10] = 16'h0800;

        reset = 1'b0; enable = 1'b1; start = 1'b0; step = 1'b0;
        zf = 1'b0; nf = 1'b0; cf = 1'b0; dm_ack = 1'b0;
        applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 0);
        checkOutput("rst_state", state, 0);
        checkOutput("rst_pc", pc, 8'h00);
        checkOutput("rst_ir", ir, 16'h0000);
        checkOutput("rst_strobes", {alu_en, flag_we, reg_we, dm_req, dm_we, branch_taken, halted}, 0);
        checkOutput("rst_fault", fault, 0);
        reset = 1'b1;

        // LOAD with two wait cycles
        applyStimulus(1, 1, 0);
        checkOutput("ld_if", state, 1);
        applyStimulus(0, 1, 0);
        checkOutput("ld_id", state, 2);
        checkOutput("ld_ir", ir, 16'h1100);
        applyStimulus(0, 1, 0);
        checkOutput("ld_ex", state, 3);
        checkOutput("ld_ex_flag_we", flag_we, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, (i == 0) ? 1'b0 : 1'b0);
            checkOutput("ld_mem_state", state, 4);
            checkOutput("ld_mem_req", {dm_req, dm_we}, 2'b10);
            if (i == 2) dm_ack = 1'b1;
        end
        applyStimulus(0, 1, 1);
        checkOutput("ld_wb", state, 5);
        checkOutput("ld_wb_reg_we", reg_we, 1);
        checkOutput("ld_wb_req", dm_req, 0);
        applyStimulus(0, 1, 0);
        checkOutput("ld_next_if", state, 1);
        checkOutput("ld_next_pc", pc, 8'h01);
        checkOutput("ld_reg_we_off", reg_we, 0);

        // NOP at 01, then ADD at 02 with a stray start pulse in ID
        applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 0);
        checkOutput("nop_ex_flags", {alu_en, flag_we}, 2'b10);
        applyStimulus(0, 1, 0);
        checkOutput("add_if_pc", pc, 8'h02);
        applyStimulus(0, 1, 0);
        checkOutput("add_ir", ir, 16'h4312);
        applyStimulus(1, 1, 0);
        checkOutput("add_ex", state, 3);
        checkOutput("add_ex_strobes", {alu_en, flag_we, reg_we}, 3'b110);
        applyStimulus(0, 1, 0);
        checkOutput("add_wb_strobes", {alu_en, flag_we, reg_we}, 3'b001);
        applyStimulus(0, 1, 0);
        checkOutput("add_done_state", state, 1);
        checkOutput("add_done_pc", pc, 8'h03);

        // JUMP 06, then BZ 0B taken with zf=1
        applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 0);
        checkOutput("jmp_taken", branch_taken, 1);
        zf = 1'b1;
        applyStimulus(0, 1, 0);
        checkOutput("jmp_pc", pc, 8'h06);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 0);
        checkOutput("bz1_taken", branch_taken, 1);
        applyStimulus(0, 1, 0);
        checkOutput("bz1_pc", pc, 8'h0B);
        checkOutput("bz1_pulse_off", branch_taken, 0);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 0);
        zf = 1'b0;
        applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 0);
        checkOutput("bz0_taken", branch_taken, 0);
        applyStimulus(0, 1, 0);
        checkOutput("bz0_pc", pc, 8'h07);

        // JUMP 10, HALT
        applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 0);
        checkOutput("halt_if_pc", pc, 8'h10);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 0);
        checkOutput("halt_state", state, 6);
        checkOutput("halt_flag", halted, 1);
        checkOutput("halt_pc", pc, 8'h11);
        applyStimulus(0, 1, 0);
        checkOutput("halt_hold", state, 6);
        checkOutput("halt_strobes", {alu_en, flag_we, reg_we, dm_req, branch_taken}, 0);

        // Illegal opcode
        imem[8'h00] = 16'h9800;
        applyStimulus(1, 1, 0);
        checkOutput("ill_restart_pc", pc, 8'h00);
        checkOutput("ill_restart_halted", halted, 0);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 0);
        checkOutput("ill_state", state, 6);
        checkOutput("ill_fault", fault, 2'b01);

        // STORE timeout
        imem[8'h00] = 16'h1800;
        applyStimulus(1, 1, 0);
        checkOutput("st_fault_clr", fault, 0);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 0);
        checkOutput("st_mem1", {state, dm_req, dm_we}, {3'd4, 2'b11});
        for (int i = 0; i < 15; i++) applyStimulus(0, 1, 0);
        checkOutput("st_mem16", {state, dm_req, dm_we}, {3'd4, 2'b11});
        applyStimulus(0, 1, 0);
        checkOutput("st_tmo_state", state, 6);
        checkOutput("st_tmo_fault", fault, 2'b10);
        checkOutput("st_tmo_req", dm_req, 0);

        // STORE timeout with a 5-cycle enable pause
        applyStimulus(1, 1, 0);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0);
            checkOutput("pause_state", state, 4);
            checkOutput("pause_req", dm_req, 0);
        end
        for (int i = 0; i < 11; i++) applyStimulus(0, 1, 0);
        checkOutput("pause_still_mem", state, 4);
        applyStimulus(0, 1, 0);
        checkOutput("pause_tmo_state", state, 6);
        checkOutput("pause_tmo_fault", fault, 2'b10);

        // PC wrap: JUMP FF, ADD at FF
        imem[8'h00] = 16'hC0FF;
        imem[8'hFF] = 16'h4312;
        applyStimulus(1, 1, 0);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 0);
        checkOutput("wrap_if_pc", pc, 8'hFF);
        applyStimulus(0, 1, 0);
        checkOutput("wrap_pc", pc, 8'h00);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 0);
        checkOutput("wrap_next_if", {state, pc}, {3'd1, 8'h00});

        // Async reset during MEM
        imem[8'h00] = 16'h1100;
        applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 0);
        checkOutput("arst_pre_req", dm_req, 1);
        #2 reset = 1'b0;
        #1;
        checkOutput("arst_state", state, 0);
        checkOutput("arst_req", dm_req, 0);
        checkOutput("arst_pc", pc, 8'h00);
        reset = 1'b1;
        applyStimulus(0, 1, 0);
        checkOutput("arst_idle_hold", state, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
